// File: rtl/wb_stage_regfile.sv
// ----------------------------------------------------------------------------
// wb_stage_regfile
//   Write-back stage register file of the pipeline: 8 x 8-bit registers.
//   It also drives the write-back data mux, the EX-stage forwarding selects
//   and a saturating count of committed register writes.
//
// Ports
//   Clk                      clock, rising-edge
//   Reset                    asynchronous, active-low reset
//   EX_WB_Shift_Result[7:0]  shift-unit result from EX/WB
//   EX_WB_Data1[7:0]         move/store operand from EX/WB
//   EX_WB_RegWrite           WB instruction writes the register file
//   EX_WB_SMCtrl             write-back select (0 = shift, 1 = Data1)
//   EX_WB_Write_Reg_Num[2:0] destination register
//   Read_Reg_Num1/2[2:0]     ID-stage source registers
//   ID_EX_Read_Reg_Num1/2    EX-stage source registers
//   Read_Data1/2[7:0]        ID-stage read data (write-through bypassed)
//   WB_Data[7:0]             selected write-back value
//   FwdCtrl1/2[1:0]          EX forwarding select (00 none, 10 shift, 11 Data1)
//   Retire_Count[15:0]       committed-write count, saturating
// ----------------------------------------------------------------------------
module wb_stage_regfile #(
   parameter int unsigned RESET_INIT = 0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [7:0]  EX_WB_Shift_Result,
   input  logic [7:0]  EX_WB_Data1,
   input  logic        EX_WB_RegWrite,
   input  logic        EX_WB_SMCtrl,
   input  logic [2:0]  EX_WB_Write_Reg_Num,
   input  logic [2:0]  Read_Reg_Num1,
   input  logic [2:0]  Read_Reg_Num2,
   input  logic [2:0]  ID_EX_Read_Reg_Num1,
   input  logic [2:0]  ID_EX_Read_Reg_Num2,
   output logic [7:0]  Read_Data1,
   output logic [7:0]  Read_Data2,
   output logic [7:0]  WB_Data,
   output logic [1:0]  FwdCtrl1,
   output logic [1:0]  FwdCtrl2,
   output logic [15:0] Retire_Count
);

   logic [7:0]  r_regs [8];
   logic [15:0] r_retire_count;

   logic [7:0]  w_wb_data;
   logic        w_byp1;
   logic        w_byp2;
   logic        w_fwd_hit1;
   logic        w_fwd_hit2;

   assign w_wb_data = EX_WB_SMCtrl ? EX_WB_Data1 : EX_WB_Shift_Result;

   // Bypass is gated by Reset: while held in reset no write can land, so
   // the read ports must show the reset contents rather than WB_Data.
   assign w_byp1 = Reset && EX_WB_RegWrite && (EX_WB_Write_Reg_Num == Read_Reg_Num1);
   assign w_byp2 = Reset && EX_WB_RegWrite && (EX_WB_Write_Reg_Num == Read_Reg_Num2);

   assign w_fwd_hit1 = EX_WB_RegWrite && (EX_WB_Write_Reg_Num == ID_EX_Read_Reg_Num1);
   assign w_fwd_hit2 = EX_WB_RegWrite && (EX_WB_Write_Reg_Num == ID_EX_Read_Reg_Num2);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 8; i++) begin
            r_regs[i] <= (RESET_INIT != 0) ? 8'(i) : 8'h00;
         end
         r_retire_count <= 16'h0000;
      end else if (EX_WB_RegWrite) begin
         r_regs[EX_WB_Write_Reg_Num] <= w_wb_data;
         if (r_retire_count != 16'hFFFF) begin
            r_retire_count <= r_retire_count + 16'd1;
         end
      end
   end

   assign WB_Data      = w_wb_data;
   assign Read_Data1   = w_byp1 ? w_wb_data : r_regs[Read_Reg_Num1];
   assign Read_Data2   = w_byp2 ? w_wb_data : r_regs[Read_Reg_Num2];
   // Encoding {1, SMCtrl} gives 10 for shift and 11 for Data1; 01 is unreachable.
   assign FwdCtrl1     = w_fwd_hit1 ? {1'b1, EX_WB_SMCtrl} : 2'b00;
   assign FwdCtrl2     = w_fwd_hit2 ? {1'b1, EX_WB_SMCtrl} : 2'b00;
   assign Retire_Count = r_retire_count;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// ----------------------------------------------------------------------------
// tb_wb_stage_regfile
//   Self-checking bench for wb_stage_regfile (RESET_INIT = 1). A behavioural
//   model (register array + integer write counter) predicts every output.
// ----------------------------------------------------------------------------
module tb_wb_stage_regfile;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [7:0]  shift_res, data1;
   logic        reg_write, sm_ctrl;
   logic [2:0]  wr_num, rd_num1, rd_num2, idex_num1, idex_num2;
   logic [7:0]  rd_data1, rd_data2, wb_data;
   logic [1:0]  fwd1, fwd2;
   logic [15:0] retire_count;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   int unsigned m_regs [8];
   int unsigned m_count;

   always #20 Clk = ~Clk;

   wb_stage_regfile #(.RESET_INIT(1)) dut (
      .Clk                 (Clk),
      .Reset               (Reset),
      .EX_WB_Shift_Result  (shift_res),
      .EX_WB_Data1         (data1),
      .EX_WB_RegWrite      (reg_write),
      .EX_WB_SMCtrl        (sm_ctrl),
      .EX_WB_Write_Reg_Num (wr_num),
      .Read_Reg_Num1       (rd_num1),
      .Read_Reg_Num2       (rd_num2),
      .ID_EX_Read_Reg_Num1 (idex_num1),
      .ID_EX_Read_Reg_Num2 (idex_num2),
      .Read_Data1          (rd_data1),
      .Read_Data2          (rd_data2),
      .WB_Data             (wb_data),
      .FwdCtrl1            (fwd1),
      .FwdCtrl2            (fwd2),
      .Retire_Count        (retire_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = i;
      m_count = 0;
   endtask

   function automatic int unsigned exp_wb();
      return sm_ctrl ? 32'(data1) : 32'(shift_res);
   endfunction

   function automatic int unsigned exp_read(input logic [2:0] n);
      if (Reset && reg_write && wr_num == n) return exp_wb();
      return m_regs[n];
   endfunction

   function automatic int unsigned exp_fwd(input logic [2:0] n);
      if (reg_write && wr_num == n) return sm_ctrl ? 32'd3 : 32'd2;
      return 0;
   endfunction

   task automatic check_comb();
      chk("wb_data", 32'(wb_data), exp_wb());
      chk("read1",   32'(rd_data1), exp_read(rd_num1));
      chk("read2",   32'(rd_data2), exp_read(rd_num2));
      chk("fwd1",    32'(fwd1), exp_fwd(idex_num1));
      chk("fwd2",    32'(fwd2), exp_fwd(idex_num2));
   endtask

   // Called at a falling edge; drives one cycle, checks, returns at the next falling edge.
   task automatic apply(input logic a_we, input logic a_sm, input logic [2:0] a_wn,
                        input logic [7:0] a_sh, input logic [7:0] a_d1,
                        input logic [2:0] a_r1, input logic [2:0] a_r2,
                        input logic [2:0] a_i1, input logic [2:0] a_i2);
      reg_write = a_we; sm_ctrl = a_sm; wr_num = a_wn;
      shift_res = a_sh; data1 = a_d1;
      rd_num1 = a_r1; rd_num2 = a_r2; idex_num1 = a_i1; idex_num2 = a_i2;
      #1;
      check_comb();
      @(posedge Clk);
      if (Reset && reg_write) begin
         m_regs[wr_num] = exp_wb();
         if (m_count < 32'hFFFF) m_count++;
      end
      #1;
      chk("retire", 32'(retire_count), m_count);
      @(negedge Clk);
   endtask

   task automatic read_all();
      reg_write = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd_num1 = 3'(i);
         rd_num2 = 3'(7 - i);
         #1;
         chk("rd_all1", 32'(rd_data1), m_regs[i]);
         chk("rd_all2", 32'(rd_data2), m_regs[7 - i]);
      end
   endtask

   initial begin
      int guard;
      Reset = 1'b1;
      shift_res = '0; data1 = '0; reg_write = 1'b0; sm_ctrl = 1'b0;
      wr_num = '0; rd_num1 = '0; rd_num2 = '0; idex_num1 = '0; idex_num2 = '0;
      model_reset();

      // Reset state, bypass suppressed while held in reset
      #2 Reset = 1'b0;
      #1;
      chk("rst_count", 32'(retire_count), 0);
      for (int i = 0; i < 8; i++) begin
         rd_num1 = 3'(i); rd_num2 = 3'(i); reg_write = 1'b1; wr_num = 3'(i);
         shift_res = 8'hFF; idex_num1 = 3'(i); idex_num2 = 3'(i ^ 1);
         #1;
         check_comb();
         chk("rst_read", 32'(rd_data1), i);
      end
      @(posedge Clk); #1;
      chk("rst_nowrite_cnt", 32'(retire_count), 0);
      read_all();
      @(negedge Clk);
      Reset = 1'b1;

      // First edge after reset writes; bypass then stored value
      apply(1, 0, 3'd3, 8'hA5, 8'h00, 3'd3, 3'd0, 3'd0, 3'd0);
      chk("byp_stored_cnt", 32'(retire_count), 1);
      apply(0, 0, 3'd0, 8'h00, 8'h00, 3'd3, 3'd3, 3'd0, 3'd0);
      chk("stored_a5", 32'(rd_data1), 32'hA5);

      // Forwarding selects
      apply(1, 1, 3'd5, 8'h0F, 8'hF0, 3'd5, 3'd2, 3'd5, 3'd2);
      apply(1, 0, 3'd5, 8'h0F, 8'hF0, 3'd5, 3'd5, 3'd5, 3'd2);
      apply(0, 0, 3'd5, 8'h0F, 8'hF0, 3'd5, 3'd5, 3'd5, 3'd5);
      chk("fwd_off", 32'(fwd1), 0);

      // Back-to-back writes to reg 6
      model_reset();
      Reset = 1'b0; #1; Reset = 1'b1;
      apply(1, 1, 3'd6, 8'h99, 8'h11, 3'd6, 3'd0, 3'd6, 3'd6);
      apply(1, 1, 3'd6, 8'h99, 8'h22, 3'd6, 3'd6, 3'd1, 3'd6);
      apply(0, 0, 3'd0, 8'h00, 8'h00, 3'd6, 3'd6, 3'd0, 3'd0);
      chk("b2b_reg6", 32'(rd_data1), 32'h22);
      chk("b2b_count", 32'(retire_count), 2);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         apply(1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
               3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      end
      read_all();

      // Reset pulse between edges clears reg 1 and the counter immediately
      apply(1, 0, 3'd1, 8'h3C, 8'h00, 3'd1, 3'd1, 3'd0, 3'd0);
      reg_write = 1'b0; rd_num1 = 3'd1;
      #1 chk("pre_rst_reg1", 32'(rd_data1), 32'h3C);
      #4 Reset = 1'b0;
      model_reset();
      #1;
      chk("rst_reg1", 32'(rd_data1), 1);
      chk("rst_cnt0", 32'(retire_count), 0);
      #4 Reset = 1'b1;

      // Reset asserted just before an edge with a pending write
      reg_write = 1'b1; sm_ctrl = 1'b1; wr_num = 3'd4; data1 = 8'h77; rd_num1 = 3'd4;
      #8 Reset = 1'b0;
      #1 chk("rst_nobyp", 32'(rd_data1), 4);
      @(posedge Clk); #1;
      chk("rst_drop_wr", 32'(rd_data1), 4);
      chk("rst_drop_cnt", 32'(retire_count), 0);
      @(negedge Clk);
      Reset = 1'b1;
      apply(1, 1, 3'd4, 8'h00, 8'h77, 3'd4, 3'd0, 3'd0, 3'd0);
      chk("post_rst_wr", 32'(rd_data1), 32'h77);

      // Saturation of the retire counter
      guard = 0;
      while (m_count < 32'hFFFE && guard < 70000) begin
         apply(1, 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
               3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
         guard++;
      end
      chk("sat_pre", 32'(retire_count), 32'hFFFE);
      for (int k = 0; k < 3; k++) begin
         apply(1, 0, 3'($urandom), 8'($urandom), 8'($urandom), 3'd0, 3'd7, 3'd1, 3'd2);
      end
      chk("sat_ffff", 32'(retire_count), 32'hFFFF);
      apply(0, 0, 3'd0, 8'h00, 8'h00, 3'd2, 3'd5, 3'd0, 3'd0);
      chk("sat_hold", 32'(retire_count), 32'hFFFF);
      read_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
